// File: rtl/song_loader_if.sv
// Byte-stream input, RAM write port and frame status of the song loader.
// The loader sits on the slave side. The byte source and RAM owner sit on the master side.
interface song_loader_if;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       wr_ready;
    logic       wr_en;
    logic [1:0] wr_sel;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_done;
    logic       frame_ok;
    logic [2:0] err_code;
    logic [7:0] song_length;

    modport slave (
        input  din, din_valid, wr_ready,
        output din_ready, wr_en, wr_sel, wr_addr, wr_data,
               frame_done, frame_ok, err_code, song_length
    );

    modport master (
        output din, din_valid, wr_ready,
        input  din_ready, wr_en, wr_sel, wr_addr, wr_data,
               frame_done, frame_ok, err_code, song_length
    );
endinterface

// File: rtl/song_loader.sv
// Parses framed uploads (A5 | TYPE | ADDR | LEN | data | CSUM) and turns them into
// sequential writes into the bar, pattern and song-map tables of the song player.
module song_loader #(
    parameter int BAR_DEPTH      = 128,
    parameter int PAT_DEPTH      = 40,
    parameter int SONG_DEPTH     = 24,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic          main_clk,
    input  logic          rst_n,
    song_loader_if.slave  bus
);
    typedef enum logic [2:0] {S_HUNT, S_TYPE, S_ADDR, S_LEN, S_DATA, S_CSUM} state_t;

    state_t      state_q, state_d;
    logic        ready_en_q;
    logic [1:0]  type_q, type_d;
    logic [7:0]  addr_q, addr_d;
    logic [8:0]  rem_q, rem_d;
    logic [8:0]  idx_q, idx_d;
    logic [7:0]  sum_q, sum_d;
    logic [15:0] tmo_q, tmo_d;
    logic        wr_en_q, wr_en_d;
    logic [1:0]  wr_sel_q, wr_sel_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic [2:0]  err_q, err_d;
    logic [7:0]  song_len_q, song_len_d;

    logic        accept;
    logic [7:0]  sum_next;
    logic [8:0]  len_full;
    logic [8:0]  tgt_addr;
    logic [8:0]  depth;
    logic [2:0]  err_set;

    // Backpressure only while streaming data, so the RAM side can stall the source.
    assign bus.din_ready = ready_en_q & ((state_q != S_DATA) | bus.wr_ready);
    assign accept        = bus.din_valid & bus.din_ready;
    assign sum_next      = sum_q + bus.din;
    assign len_full      = (bus.din == 8'h00) ? 9'd256 : {1'b0, bus.din};
    assign tgt_addr      = {1'b0, addr_q} + idx_q;

    always_comb begin
        case (type_q)
            2'd1:    depth = 9'(BAR_DEPTH);
            2'd2:    depth = 9'(PAT_DEPTH);
            default: depth = 9'(SONG_DEPTH);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        tmo_d      = 16'd0;
        wr_en_d    = 1'b0;
        wr_sel_d   = wr_sel_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        ok_d       = 1'b0;
        err_d      = err_q;
        song_len_d = song_len_q;
        err_set    = 3'd0;

        if (state_q != S_HUNT && !accept) begin
            if (tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_HUNT;
                done_d  = 1'b1;
                err_set = 3'd4;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end

        if (accept) begin
            case (state_q)
                S_HUNT: begin
                    if (bus.din == 8'hA5) begin
                        state_d = S_TYPE;
                        err_d   = 3'd0;
                        sum_d   = 8'h00;
                    end
                end
                S_TYPE: begin
                    if (bus.din >= 8'h01 && bus.din <= 8'h03) begin
                        type_d  = bus.din[1:0];
                        sum_d   = sum_next;
                        state_d = S_ADDR;
                    end else begin
                        err_set = 3'd1;
                        done_d  = 1'b1;
                        state_d = S_HUNT;
                    end
                end
                S_ADDR: begin
                    addr_d  = bus.din;
                    sum_d   = sum_next;
                    state_d = S_LEN;
                end
                S_LEN: begin
                    rem_d   = len_full;
                    idx_d   = 9'd0;
                    sum_d   = sum_next;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    sum_d = sum_next;
                    // Out-of-range bytes still count, but never wrap into low entries.
                    if (tgt_addr < depth) begin
                        wr_en_d   = 1'b1;
                        wr_sel_d  = type_q;
                        wr_addr_d = tgt_addr[7:0];
                        wr_data_d = bus.din;
                    end else begin
                        err_set = 3'd2;
                    end
                    idx_d = idx_q + 9'd1;
                    rem_d = rem_q - 9'd1;
                    if (rem_q == 9'd1) state_d = S_CSUM;
                end
                S_CSUM: begin
                    done_d  = 1'b1;
                    state_d = S_HUNT;
                    if (sum_next == 8'h00) begin
                        ok_d = (err_q == 3'd0);
                        if (err_q == 3'd0 && type_q == 2'd3)
                            song_len_d = (tgt_addr > 9'(SONG_DEPTH)) ? 8'(SONG_DEPTH) : tgt_addr[7:0];
                    end else begin
                        err_set = 3'd3;
                    end
                end
                default: state_d = S_HUNT;
            endcase
        end

        // The first error of a frame wins; only a fresh sync clears it.
        if (err_set != 3'd0 && err_q == 3'd0) err_d = err_set;
    end

    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_HUNT;
            ready_en_q <= 1'b0;
            type_q     <= 2'd0;
            addr_q     <= 8'h00;
            rem_q      <= 9'd0;
            idx_q      <= 9'd0;
            sum_q      <= 8'h00;
            tmo_q      <= 16'd0;
            wr_en_q    <= 1'b0;
            wr_sel_q   <= 2'd0;
            wr_addr_q  <= 8'h00;
            wr_data_q  <= 8'h00;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 3'd0;
            song_len_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            type_q     <= type_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            tmo_q      <= tmo_d;
            wr_en_q    <= wr_en_d;
            wr_sel_q   <= wr_sel_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            song_len_q <= song_len_d;
        end
    end

    assign bus.wr_en       = wr_en_q;
    assign bus.wr_sel      = wr_sel_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.frame_done  = done_q;
    assign bus.frame_ok    = ok_q;
    assign bus.err_code    = err_q;
    assign bus.song_length = song_len_q;
endmodule

// File: tb/tb_song_loader.sv
// Scoreboard bench for song_loader: stimulus pushes expected writes and frame results,
// an independent monitor pops and compares whenever wr_en or frame_done is seen.
module tb_song_loader;
    localparam int TMO = 65535;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed { logic [1:0] sel; logic [7:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { logic ok; logic [2:0] err; logic [7:0] slen; } fr_t;

    logic main_clk = 1'b0;
    logic rst_n    = 1'b0;
    always #5 main_clk = ~main_clk;

    song_loader_if bus();
    song_loader dut (.main_clk(main_clk), .rst_n(rst_n), .bus(bus));

    wr_t wr_q[$];
    fr_t fr_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  frames_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every DUT-presented write and frame status against the scoreboard.
    always @(negedge main_clk) begin
        if (rst_n) begin
            if (bus.wr_en) begin
                if (wr_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_write: got sel=%0h addr=%0h data=%0h, expected none",
                             bus.wr_sel, bus.wr_addr, bus.wr_data);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    $display("write sel=%0h addr=%02h data=%02h", bus.wr_sel, bus.wr_addr, bus.wr_data);
                    check("wr_sel",  {30'd0, bus.wr_sel}, {30'd0, e.sel});
                    check("wr_addr", {24'd0, bus.wr_addr}, {24'd0, e.addr});
                    check("wr_data", {24'd0, bus.wr_data}, {24'd0, e.data});
                end
            end
            if (bus.frame_done) begin
                frames_seen++;
                if (fr_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_frame: got ok=%0b err=%0d, expected none",
                             bus.frame_ok, bus.err_code);
                end else begin
                    fr_t f;
                    f = fr_q.pop_front();
                    $display("frame ok=%0b err=%0d song_length=%0d", bus.frame_ok, bus.err_code, bus.song_length);
                    check("frame_ok",    {31'd0, bus.frame_ok}, {31'd0, f.ok});
                    check("err_code",    {29'd0, bus.err_code}, {29'd0, f.err});
                    check("song_length", {24'd0, bus.song_length}, {24'd0, f.slen});
                end
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        bus.din = b;
        bus.din_valid = 1'b1;
        while (!bus.din_ready && t < 100) begin
            @(negedge main_clk);
            t++;
        end
        if (t >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL byte_accept: got din_ready=0 for %0d cycles, expected acceptance", t);
        end
        @(posedge main_clk);
        @(negedge main_clk);
        bus.din_valid = 1'b0;
    endtask

    task automatic send_bytes(input byte_q_t bq);
        foreach (bq[i]) send_byte(bq[i]);
    endtask

    task automatic wait_frames(input int target);
        int t;
        t = 0;
        while (frames_seen < target && t < 200) begin
            @(negedge main_clk);
            t++;
        end
        check("frame_count", frames_seen, target);
    endtask

    initial begin
        int cyc;
        bus.din = 8'h00;
        bus.din_valid = 1'b0;
        bus.wr_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge main_clk);
        check("rst_din_ready",   {31'd0, bus.din_ready}, 32'd0);
        check("rst_wr_en",       {31'd0, bus.wr_en}, 32'd0);
        check("rst_wr_bus",      {14'd0, bus.wr_sel, bus.wr_addr, bus.wr_data}, 32'd0);
        check("rst_frame",       {30'd0, bus.frame_done, bus.frame_ok}, 32'd0);
        check("rst_err_code",    {29'd0, bus.err_code}, 32'd0);
        check("rst_song_length", {24'd0, bus.song_length}, 32'd0);
        rst_n = 1'b1;
        #1 check("din_ready_at_release", {31'd0, bus.din_ready}, 32'd0);
        @(negedge main_clk);
        check("din_ready_after_release", {31'd0, bus.din_ready}, 32'd1);

        // Good bar frame
        wr_q.push_back('{2'd1, 8'h10, 8'h31});
        wr_q.push_back('{2'd1, 8'h11, 8'h42});
        fr_q.push_back('{1'b1, 3'd0, 8'd0});
        send_bytes('{8'hA5, 8'h01, 8'h10, 8'h02, 8'h31, 8'h42, 8'h7A});
        wait_frames(1);

        // Song-map frame: 03+00+03+00+01+02 = 09, so CSUM = F7
        for (int i = 0; i < 3; i++) wr_q.push_back('{2'd3, 8'(i), 8'(i)});
        fr_q.push_back('{1'b1, 3'd0, 8'd3});
        send_bytes('{8'hA5, 8'h03, 8'h00, 8'h03, 8'h00, 8'h01, 8'h02, 8'hF7});
        wait_frames(2);

        // Bad checksum: writes still happen, song_length unchanged
        wr_q.push_back('{2'd1, 8'h10, 8'h31});
        wr_q.push_back('{2'd1, 8'h11, 8'h42});
        fr_q.push_back('{1'b0, 3'd3, 8'd3});
        send_bytes('{8'hA5, 8'h01, 8'h10, 8'h02, 8'h31, 8'h42, 8'h7B});
        wait_frames(3);

        // Pattern overflow with 5-cycle RAM stall: 02+27+02+05+06 = 36, CSUM = CA
        wr_q.push_back('{2'd2, 8'h27, 8'h05});
        fr_q.push_back('{1'b0, 3'd2, 8'd3});
        send_bytes('{8'hA5, 8'h02, 8'h27, 8'h02});
        bus.wr_ready = 1'b0;
        fork
            begin
                repeat (5) @(posedge main_clk);
                #1 bus.wr_ready = 1'b1;
            end
        join_none
        @(negedge main_clk);
        check("din_ready_stalled", {31'd0, bus.din_ready}, 32'd0);
        send_bytes('{8'h05, 8'h06, 8'hCA});
        wait_frames(4);

        // Bad type: aborts at once, trailing bytes hunted through, error sticky
        fr_q.push_back('{1'b0, 3'd1, 8'd3});
        send_bytes('{8'hA5, 8'h04, 8'h00, 8'h00});
        wait_frames(5);
        check("err_sticky", {29'd0, bus.err_code}, 32'd1);

        // Garbage then a stalled frame: timeout after TMO idle cycles
        fr_q.push_back('{1'b0, 3'd4, 8'd3});
        send_bytes('{8'h00, 8'hFF, 8'hA5, 8'h01});
        cyc = 0;
        while (!bus.frame_done && cyc < TMO + 100) begin
            @(negedge main_clk);
            cyc++;
        end
        check("timeout_window", {31'd0, (cyc >= TMO - 1 && cyc <= TMO + 1)}, 32'd1);
        if (cyc < TMO - 1 || cyc > TMO + 1)
            $display("timeout observed after %0d idle cycles, expected about %0d", cyc, TMO);
        wait_frames(6);

        // Fresh sync clears the error, then a one-byte bar frame: 01+00+01+AB = AD, CSUM = 53
        wr_q.push_back('{2'd1, 8'h00, 8'hAB});
        fr_q.push_back('{1'b1, 3'd0, 8'd3});
        send_byte(8'hA5);
        check("err_cleared_by_sync", {29'd0, bus.err_code}, 32'd0);
        send_bytes('{8'h01, 8'h00, 8'h01, 8'hAB, 8'h53});
        wait_frames(7);

        repeat (5) @(negedge main_clk);
        check("writes_drained", wr_q.size(), 32'd0);
        check("frames_drained", fr_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
